seven_segment_reader: RTL and testbench

Recovers BCD digits from a multiplexed, active-high seven-segment display bus, performing the inverse of the team's BCD-to-segment decoder. It watches the segment lines and the one-hot digit enables, captures each digit once its pattern has been stable for a set number of cycles, and maps the pattern back to a 4-bit value. When every digit position has been captured, it presents the frame on a valid/ready output. It sits between a display-driving source, or an external display tap, and downstream checking or logging logic.

---
 rtl/seven_segment_reader.sv | 141 ++++++++++++++
 tb/tb_seven_segment_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// Recovers BCD digits from a multiplexed active-high seven-segment bus and
// presents each completed multi-digit frame on a valid/ready output.
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            io_seg,
    input  logic [DIGITS-1:0]     io_an,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [4*DIGITS-1:0]   io_out_bits,
    output logic                  io_out_err,
    output logic                  io_overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [4*DIGITS-1:0] nib_q, nib_d;
    logic                err_acc_q, err_acc_d;
    logic                valid_q, valid_d;
    logic [4*DIGITS-1:0] bits_q, bits_d;
    logic                out_err_q, out_err_d;
    logic                overrun_q, overrun_d;

    logic                same;
    logic                capture;
    logic [3:0]          dec_val;
    logic                dec_inv;
    logic [DIGITS-1:0]   mask_next;
    logic                err_next;

    // Inverse of the segment decoder; no legal digit maps to 0xF.
    always_comb begin
        dec_val = 4'hF;
        case (io_seg)
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            default: dec_val = 4'hF;
        endcase
        dec_inv = (dec_val == 4'hF);
    end

    // The value being sampled this edge is io_*; it becomes the new seg_q/an_q.
    assign same    = ({io_an, io_seg} == {an_q, seg_q});
    assign capture = same && (cnt_q == CNT_ARM) && $onehot(io_an);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_d[4*gi +: 4] = (capture && io_an[gi]) ? dec_val : nib_q[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        seg_d     = io_seg;
        an_d      = io_an;
        cnt_d     = CNT_ONE;
        mask_d    = mask_q;
        err_acc_d = err_acc_q;
        valid_d   = valid_q;
        bits_d    = bits_q;
        out_err_d = out_err_q;
        overrun_d = 1'b0;
        mask_next = mask_q | io_an;
        err_next  = err_acc_q | dec_inv;

        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end

        if (valid_q && io_out_ready) begin
            valid_d = 1'b0;
        end

        if (capture) begin
            if (&mask_next) begin
                if (!valid_q || io_out_ready) begin
                    valid_d   = 1'b1;
                    bits_d    = nib_d;
                    out_err_d = err_next;
                end else begin
                    overrun_d = 1'b1;
                end
                mask_d    = '0;
                err_acc_d = 1'b0;
            end else begin
                mask_d    = mask_next;
                err_acc_d = err_next;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q     <= '0;
            an_q      <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            nib_q     <= '0;
            err_acc_q <= 1'b0;
            valid_q   <= 1'b0;
            bits_q    <= '0;
            out_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            an_q      <= an_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            nib_q     <= nib_d;
            err_acc_q <= err_acc_d;
            valid_q   <= valid_d;
            bits_q    <= bits_d;
            out_err_q <= out_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign io_out_valid = valid_q;
    assign io_out_bits  = bits_q;
    assign io_out_err   = out_err_q;
    assign io_overrun   = overrun_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader: stimulus pushes expected frames,
// a negedge monitor pops and compares each accepted frame.
module tb_seven_segment_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  io_seg = 7'h00;
    logic [3:0]  io_an = 4'b0000;
    logic        io_out_valid;
    logic        io_out_ready = 1'b1;
    logic [15:0] io_out_bits;
    logic        io_out_err;
    logic        io_overrun;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;
    logic [16:0] exp_q[$];

    seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_seg       (io_seg),
        .io_an        (io_an),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_err   (io_out_err),
        .io_overrun   (io_overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    // Inputs change 1 time unit after an edge and stay for n edges.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        io_an  = an;
        io_seg = seg;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b0001, s0, 5);
        drive(4'b0010, s1, 5);
        drive(4'b0100, s2, 5);
        drive(4'b1000, s3, 5);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (io_overrun) ovr_cnt++;
            if (io_out_valid && io_out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got bits 0x%h, no frame expected", io_out_bits);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("frame_bits", 32'(io_out_bits), 32'(e[15:0]));
                    check("frame_err", 32'(io_out_err), 32'(e[16]));
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 32'(io_out_valid), 32'd0);
        check("rst_bits", 32'(io_out_bits), 32'd0);
        check("rst_err", 32'(io_out_err), 32'd0);
        check("rst_overrun", 32'(io_overrun), 32'd0);
        reset = 1'b0;

        // Basic frame 1,2,3,4 with latency check on the last digit
        exp_q.push_back({1'b0, 16'h4321});
        drive(4'b0001, 7'h06, 5);
        drive(4'b0010, 7'h5B, 5);
        drive(4'b0100, 7'h4F, 5);
        io_an  = 4'b1000;
        io_seg = 7'h66;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("basic_valid_e2", 32'(io_out_valid), 32'd0);
        @(negedge clock);
        check("basic_valid_e3", 32'(io_out_valid), 32'd1);
        @(posedge clock);
        #1;
        drive(4'b1000, 7'h66, 1);

        // Glitch rejection on digit 0: expect 9, never 0 or 8
        exp_q.push_back({1'b0, 16'h3219});
        drive(4'b0001, 7'h3F, 2);
        drive(4'b0001, 7'h7F, 1);
        drive(4'b0001, 7'h6F, 4);
        drive(4'b0010, 7'h06, 5);
        drive(4'b0100, 7'h5B, 5);
        drive(4'b1000, 7'h4F, 5);

        // Invalid pattern on digit 2
        exp_q.push_back({1'b1, 16'h3F10});
        scan(7'h3F, 7'h06, 7'h49, 7'h4F);

        // Backpressure: first frame held, second dropped with an overrun pulse
        io_out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'h4321});
        scan(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("bp_valid_held", 32'(io_out_valid), 32'd1);
        check("bp_bits_held", 32'(io_out_bits), 32'h4321);
        scan(7'h6D, 7'h7D, 7'h07, 7'h7F);
        check("bp_bits_stable", 32'(io_out_bits), 32'h4321);
        check("bp_err_stable", 32'(io_out_err), 32'd0);
        check("bp_overrun_pulses", 32'(ovr_cnt), 32'd1);
        io_out_ready = 1'b1;
        drive(4'b1000, 7'h7F, 3);
        check("bp_valid_after_xfer", 32'(io_out_valid), 32'd0);

        // Illegal enables between digits 2 and 3 must not capture
        exp_q.push_back({1'b0, 16'h4567});
        drive(4'b0001, 7'h07, 5);
        drive(4'b0010, 7'h7D, 5);
        drive(4'b0100, 7'h6D, 5);
        drive(4'b0000, 7'h7F, 10);
        drive(4'b0011, 7'h7F, 10);
        check("illegal_no_frame", 32'(io_out_valid), 32'd0);
        drive(4'b1000, 7'h66, 5);

        // Reset mid-frame after two captured digits
        drive(4'b0001, 7'h6F, 5);
        drive(4'b0010, 7'h7F, 5);
        #2;
        reset  = 1'b1;
        io_an  = 4'b0000;
        io_seg = 7'h00;
        #1;
        check("midrst_valid", 32'(io_out_valid), 32'd0);
        check("midrst_bits", 32'(io_out_bits), 32'd0);
        check("midrst_err", 32'(io_out_err), 32'd0);
        check("midrst_overrun", 32'(io_overrun), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.push_back({1'b0, 16'h8102});
        scan(7'h5B, 7'h3F, 7'h06, 7'h7F);

        repeat (10) @(posedge clock);
        #1;
        check("all_frames_seen", 32'(exp_q.size()), 32'd0);
        check("total_overruns", 32'(ovr_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
